// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: register offsets,
// FSM state encoding and core vector base.
package irq_pkg;

    localparam logic [2:0] OFF_PENDING = 3'd0;
    localparam logic [2:0] OFF_MASK    = 3'd1;
    localparam logic [2:0] OFF_GIE     = 3'd2;
    localparam logic [2:0] OFF_EOI     = 3'd3;
    localparam logic [2:0] OFF_STATUS  = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    localparam logic [31:0] VEC_BASE = 32'h80;

    // Core-side entry point for a given IRQ id.
    function automatic logic [31:0] vector_pc(input logic [2:0] id);
        return VEC_BASE * (32'(id) + 32'd1);
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser with a registered rising-edge pulse.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = rise_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pending/mask/enable registers, lowest-index
// priority and a req/ack/EOI handshake towards the core.
module irq_controller
    import irq_pkg::*;
#(
    parameter int         NUM_SRC     = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] EDGE_MASK   = 8'hFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               irq_req,
    output logic [2:0]         irq_id,
    input  logic               irq_ack,
    input  logic               bus_sel,
    input  logic               bus_we,
    input  logic [2:0]         bus_addr,
    input  logic [31:0]        bus_wd,
    output logic [31:0]        bus_rd
);

    localparam logic [NUM_SRC-1:0] EDGE = EDGE_MASK[NUM_SRC-1:0];

    logic [NUM_SRC-1:0] level, rise;
    logic [NUM_SRC-1:0] pending_q, pending_d, mask_q;
    logic [NUM_SRC-1:0] elig, w1c, ack_clr, id_hot;
    logic               gie_q, wr, eoi_wr, held;
    state_t             state_q, state_d;
    logic [2:0]         id_q, id_d, svc_q, svc_d, winner;
    logic               unused_bits;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .src  (irq_src[gi]),
            .level(level[gi]),
            .rise (rise[gi])
        );
    end

    assign unused_bits = ^bus_wd;
    assign wr     = bus_sel & bus_we;
    assign eoi_wr = wr && (bus_addr == OFF_EOI);
    assign w1c    = (wr && bus_addr == OFF_PENDING) ?
                    bus_wd[NUM_SRC-1:0] : '0;
    assign elig   = gie_q ? (pending_q & ~mask_q) : '0;

    always_comb begin
        id_hot = '0;
        winner = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_hot[i] = (id_q == 3'(i));
        end
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) winner = 3'(i);
        end
    end

    assign held    = |(elig & id_hot);
    assign ack_clr = (state_q == REQ && irq_ack) ? id_hot : '0;

    // New edge beats any clear; level sources just track the input.
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (EDGE[i])
                pending_d[i] = rise[i] |
                    (pending_q[i] & ~(w1c[i] | ack_clr[i]));
            else
                pending_d[i] = level[i];
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        svc_d   = svc_q;
        unique case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = REQ;
                    id_d    = winner;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d = SVC;
                    svc_d   = id_q;
                end else if (!held) begin
                    state_d = IDLE;
                end
            end
            SVC: begin
                if (eoi_wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            mask_q    <= '1;
            gie_q     <= 1'b0;
            state_q   <= IDLE;
            id_q      <= 3'd0;
            svc_q     <= 3'd0;
        end else begin
            pending_q <= pending_d;
            state_q   <= state_d;
            id_q      <= id_d;
            svc_q     <= svc_d;
            if (wr && bus_addr == OFF_MASK)
                mask_q <= bus_wd[NUM_SRC-1:0];
            if (wr && bus_addr == OFF_GIE)
                gie_q <= bus_wd[0];
        end
    end

    assign irq_req = (state_q == REQ);
    assign irq_id  = id_q;

    always_comb begin
        bus_rd = '0;
        if (bus_sel) begin
            case (bus_addr)
                OFF_PENDING: bus_rd = 32'(pending_q);
                OFF_MASK:    bus_rd = 32'(mask_q);
                OFF_GIE:     bus_rd = {31'b0, gie_q};
                OFF_STATUS:  bus_rd = {25'b0, svc_q, 2'b0, state_q};
                default:     bus_rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller (source 0 level, others edge).
module tb_irq_controller;
    import irq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  irq_src = '0;
    logic        irq_req;
    logic [2:0]  irq_id;
    logic        irq_ack = 1'b0;
    logic        bus_sel = 1'b0;
    logic        bus_we = 1'b0;
    logic [2:0]  bus_addr = '0;
    logic [31:0] bus_wd = '0;
    logic [31:0] bus_rd;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    irq_controller #(
        .NUM_SRC    (8),
        .SYNC_STAGES(2),
        .EDGE_MASK  (8'hFE)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_src (irq_src),
        .irq_req (irq_req),
        .irq_id  (irq_id),
        .irq_ack (irq_ack),
        .bus_sel (bus_sel),
        .bus_we  (bus_we),
        .bus_addr(bus_addr),
        .bus_wd  (bus_wd),
        .bus_rd  (bus_rd)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus_sel = 1'b1;
        bus_we = 1'b0;
        bus_addr = a;
        #1;
        d = bus_rd;
        bus_sel = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus_sel = 1'b1;
        bus_we = 1'b1;
        bus_addr = a;
        bus_wd = d;
        tick(1);
        bus_sel = 1'b0;
        bus_we = 1'b0;
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    task automatic eoi();
        bus_write(OFF_EOI, 32'h0);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (irq_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        total++;
        if (irq_req !== 1'b0 || irq_id !== 3'd0)
            $display("FAIL reset_req: got req=%0b id=%0d want 0/0",
                     irq_req, irq_id);
        else passed++;
        bus_read(OFF_PENDING, d);
        total++;
        if (d !== 32'h0) $display("FAIL reset_pending: got %h want 0", d);
        else passed++;
        bus_read(OFF_MASK, d);
        total++;
        if (d !== 32'hFF) $display("FAIL reset_mask: got %h want ff", d);
        else passed++;
        bus_read(OFF_GIE, d);
        total++;
        if (d !== 32'h0) $display("FAIL reset_gie: got %h want 0", d);
        else passed++;
        bus_read(OFF_STATUS, d);
        total++;
        if (d !== 32'h0) $display("FAIL reset_status: got %h want 0", d);
        else passed++;
        bus_addr = OFF_MASK;
        #1;
        total++;
        if (bus_rd !== 32'h0)
            $display("FAIL rd_unselected: got %h want 0", bus_rd);
        else passed++;
    endtask

    task automatic test_edge_latency();
        logic [31:0] d;
        bus_write(OFF_MASK, 32'h0);
        bus_write(OFF_GIE, 32'h1);
        irq_src[3] = 1'b1;
        tick(3);
        irq_src[3] = 1'b0;
        bus_read(OFF_PENDING, d);
        total++;
        if (d !== 32'h0) $display("FAIL latency_early: got %h want 0", d);
        else passed++;
        tick(1);
        bus_read(OFF_PENDING, d);
        total++;
        if (d !== 32'h08) $display("FAIL latency_pend: got %h want 08", d);
        else passed++;
        total++;
        if (irq_req !== 1'b0)
            $display("FAIL latency_req_early: got %0b want 0", irq_req);
        else passed++;
        tick(1);
        total++;
        if (irq_req !== 1'b1 || irq_id !== 3'd3)
            $display("FAIL latency_req: got req=%0b id=%0d want 1/3",
                     irq_req, irq_id);
        else passed++;
        ack_pulse();
        bus_read(OFF_STATUS, d);
        total++;
        if (d !== 32'h32 || irq_req !== 1'b0)
            $display("FAIL ack_status: got %h req=%0b want 32 req=0",
                     d, irq_req);
        else passed++;
        bus_read(OFF_PENDING, d);
        total++;
        if (d !== 32'h0) $display("FAIL ack_clear: got %h want 0", d);
        else passed++;
        eoi();
        bus_read(OFF_STATUS, d);
        total++;
        if (d[1:0] !== 2'd0) $display("FAIL eoi_idle: got %0d want 0", d[1:0]);
        else passed++;
    endtask

    task automatic test_two_sources();
        logic [31:0] d;
        bit ok;
        irq_src[5] = 1'b1;
        irq_src[2] = 1'b1;
        wait_req(ok);
        irq_src[5] = 1'b0;
        irq_src[2] = 1'b0;
        total++;
        if (!ok || irq_id !== 3'd2)
            $display("FAIL two_first: got ok=%0b id=%0d want 1/2", ok, irq_id);
        else passed++;
        bus_read(OFF_PENDING, d);
        total++;
        if (d !== 32'h24) $display("FAIL two_pend0: got %h want 24", d);
        else passed++;
        ack_pulse();
        bus_read(OFF_PENDING, d);
        total++;
        if (d !== 32'h20) $display("FAIL two_pend1: got %h want 20", d);
        else passed++;
        bus_read(OFF_STATUS, d);
        total++;
        if (d !== 32'h22) $display("FAIL two_status: got %h want 22", d);
        else passed++;
        tick(3);
        total++;
        if (irq_req !== 1'b0)
            $display("FAIL svc_hold: got req=%0b want 0", irq_req);
        else passed++;
        eoi();
        wait_req(ok);
        total++;
        if (!ok || irq_id !== 3'd5)
            $display("FAIL two_second: got ok=%0b id=%0d want 1/5", ok, irq_id);
        else passed++;
        ack_pulse();
        bus_read(OFF_PENDING, d);
        total++;
        if (d !== 32'h0) $display("FAIL two_pend2: got %h want 0", d);
        else passed++;
        eoi();
    endtask

    task automatic test_no_preempt();
        logic [31:0] d;
        bit ok;
        irq_src[4] = 1'b1;
        wait_req(ok);
        irq_src[4] = 1'b0;
        irq_src[6] = 1'b1;
        tick(6);
        irq_src[6] = 1'b0;
        total++;
        if (!ok || irq_req !== 1'b1 || irq_id !== 3'd4)
            $display("FAIL no_preempt: got req=%0b id=%0d want 1/4",
                     irq_req, irq_id);
        else passed++;
        bus_read(OFF_PENDING, d);
        total++;
        if (d !== 32'h50) $display("FAIL preempt_pend: got %h want 50", d);
        else passed++;
        bus_write(OFF_MASK, 32'h10);
        tick(1);
        bus_read(OFF_STATUS, d);
        total++;
        if (irq_req !== 1'b0 || d[1:0] !== 2'd0)
            $display("FAIL withdraw: got req=%0b st=%0d want 0/0",
                     irq_req, d[1:0]);
        else passed++;
        wait_req(ok);
        total++;
        if (!ok || irq_id !== 3'd6)
            $display("FAIL rearb: got ok=%0b id=%0d want 1/6", ok, irq_id);
        else passed++;
        ack_pulse();
        eoi();
        bus_write(OFF_PENDING, 32'hFF);
        bus_write(OFF_MASK, 32'h0);
    endtask

    task automatic test_ack_collision();
        logic [31:0] d;
        bit ok;
        irq_src[3] = 1'b1;
        wait_req(ok);
        irq_src[3] = 1'b0;
        tick(4);
        irq_src[3] = 1'b1;
        tick(3);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        irq_src[3] = 1'b0;
        bus_read(OFF_PENDING, d);
        total++;
        if (!ok || d[3] !== 1'b1)
            $display("FAIL collide_pend: got %h want bit3 set", d);
        else passed++;
        bus_read(OFF_STATUS, d);
        total++;
        if (d !== 32'h32) $display("FAIL collide_status: got %h want 32", d);
        else passed++;
        tick(4);
        total++;
        if (irq_req !== 1'b0)
            $display("FAIL collide_noreq: got req=%0b want 0", irq_req);
        else passed++;
        eoi();
        wait_req(ok);
        total++;
        if (!ok || irq_id !== 3'd3)
            $display("FAIL collide_rereq: got ok=%0b id=%0d want 1/3",
                     ok, irq_id);
        else passed++;
        ack_pulse();
        eoi();
    endtask

    task automatic test_level();
        logic [31:0] d;
        bit ok;
        irq_src[0] = 1'b1;
        wait_req(ok);
        total++;
        if (!ok || irq_id !== 3'd0)
            $display("FAIL level_req: got ok=%0b id=%0d want 1/0", ok, irq_id);
        else passed++;
        bus_write(OFF_PENDING, 32'h1);
        bus_read(OFF_PENDING, d);
        total++;
        if (d[0] !== 1'b1) $display("FAIL level_w1c: got %h want bit0", d);
        else passed++;
        ack_pulse();
        bus_read(OFF_STATUS, d);
        total++;
        if (d !== 32'h02) $display("FAIL level_svc: got %h want 02", d);
        else passed++;
        eoi();
        wait_req(ok);
        total++;
        if (!ok || irq_id !== 3'd0)
            $display("FAIL level_rereq: got ok=%0b id=%0d want 1/0",
                     ok, irq_id);
        else passed++;
        irq_src[0] = 1'b0;
        tick(6);
        bus_read(OFF_PENDING, d);
        total++;
        if (irq_req !== 1'b0 || d !== 32'h0)
            $display("FAIL level_drop: got req=%0b pend=%h want 0/0",
                     irq_req, d);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [7:0] set, msk, remain;
        int q[$];
        bit ok;
        bus_write(OFF_GIE, 32'h0);
        for (int it = 0; it < 8; it++) begin
            set = 8'($urandom_range(1, 127) << 1);
            msk = 8'($urandom) & 8'hFE;
            bus_write(OFF_MASK, 32'(msk));
            irq_src = set;
            tick(2);
            irq_src = '0;
            tick(5);
            bus_read(OFF_PENDING, d);
            total++;
            if (d !== 32'(set))
                $display("FAIL rnd_pend it=%0d: got %h want %h", it, d, set);
            else passed++;
            q.delete();
            for (int b = 1; b < 8; b++)
                if (set[b] && !msk[b]) q.push_back(b);
            remain = set;
            bus_write(OFF_GIE, 32'h1);
            foreach (q[j]) begin
                wait_req(ok);
                total++;
                if (!ok || irq_id !== 3'(q[j]))
                    $display("FAIL rnd_id it=%0d: got ok=%0b id=%0d want %0d",
                             it, ok, irq_id, q[j]);
                else passed++;
                remain[q[j]] = 1'b0;
                ack_pulse();
                bus_read(OFF_PENDING, d);
                total++;
                if (d !== 32'(remain))
                    $display("FAIL rnd_ack it=%0d: got %h want %h",
                             it, d, remain);
                else passed++;
                eoi();
            end
            tick(4);
            total++;
            if (irq_req !== 1'b0)
                $display("FAIL rnd_idle it=%0d: got req=%0b want 0",
                         it, irq_req);
            else passed++;
            bus_write(OFF_GIE, 32'h0);
            bus_write(OFF_PENDING, 32'hFF);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        bit ok;
        bus_write(OFF_MASK, 32'h0);
        bus_write(OFF_GIE, 32'h1);
        irq_src[2] = 1'b1;
        wait_req(ok);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (!ok || irq_req !== 1'b0 || irq_id !== 3'd0)
            $display("FAIL arst_req: got ok=%0b req=%0b id=%0d want 1/0/0",
                     ok, irq_req, irq_id);
        else passed++;
        bus_read(OFF_PENDING, d);
        total++;
        if (d !== 32'h0) $display("FAIL arst_pend: got %h want 0", d);
        else passed++;
        bus_read(OFF_GIE, d);
        total++;
        if (d !== 32'h0) $display("FAIL arst_gie: got %h want 0", d);
        else passed++;
        bus_read(OFF_MASK, d);
        total++;
        if (d !== 32'hFF) $display("FAIL arst_mask: got %h want ff", d);
        else passed++;
        irq_src = '0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_two_sources();
        test_no_preempt();
        test_ack_collision();
        test_level();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
